// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer.
// State and cause enums plus cause encodings.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    RS_ASSERT  = 2'b00,
    RS_RELEASE = 2'b01,
    RS_DONE    = 2'b10
  } rs_state_e;

  typedef enum logic [1:0] {
    RC_POR = 2'b00,
    RC_EXT = 2'b01,
    RC_SW  = 2'b10
  } rs_cause_e;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_EXT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

endpackage

// File: rtl/rst_sync_chain.sv
// DEPTH-flop synchronizer with synchronous active-low clear to 0.
// Ports: i_clk, i_clr_n, i_d (async in), o_q (synchronized out).
module rst_sync_chain #(
  parameter int DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_clr_n,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) r_q <= '0;
    else          r_q <= {r_q[DEPTH-2:0], i_d};
  end

  assign o_q = r_q[DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// Merges rst_n, ext pin and sw request; stretches, then releases
// NUM_CH resets in order. Ports: clk, rst_n, ext_rst_n_async,
// sw_rst_req, rst_n_out, busy, rst_cause (macro RSTSEQ_CAUSE_EN).
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 16,
  parameter int GAP_CYCLES     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ext_rst_n_async,
  input  logic              sw_rst_req,
  output logic [NUM_CH-1:0] rst_n_out,
  output logic              busy
`ifdef RSTSEQ_CAUSE_EN
  ,
  output logic [1:0]        rst_cause
`endif
);

  localparam int CNT_MAX =
    (STRETCH_CYCLES > GAP_CYCLES) ? STRETCH_CYCLES : GAP_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int CH_L2 = $clog2(NUM_CH + 1);
  localparam int CH_W  = (CH_L2 > 1) ? CH_L2 : 1;

  logic w_ext_sync;
  logic w_ext_act;
  logic w_src_act;

  rs_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [CH_W-1:0]   r_ch, w_ch_nxt;
  logic [NUM_CH-1:0] r_out, w_out_nxt;
  logic              r_busy, w_busy_nxt;
`ifdef RSTSEQ_CAUSE_EN
  rs_cause_e         r_cause, w_cause_nxt;
`endif

  rst_sync_chain #(
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .i_clk   (clk),
    .i_clr_n (rst_n),
    .i_d     (ext_rst_n_async),
    .o_q     (w_ext_sync)
  );

  assign w_ext_act = !w_ext_sync;
  assign w_src_act = w_ext_act || sw_rst_req;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ch_nxt    = r_ch;
    w_out_nxt   = r_out;
    w_busy_nxt  = r_busy;
`ifdef RSTSEQ_CAUSE_EN
    w_cause_nxt = r_cause;
`endif
    unique case (r_state)
      RS_ASSERT: begin
        if (w_src_act) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CNT_W'(STRETCH_CYCLES - 1)) begin
          w_out_nxt[0] = 1'b1;
          w_cnt_nxt    = '0;
          w_ch_nxt     = CH_W'(1);
          if (NUM_CH == 1) begin
            w_state_nxt = RS_DONE;
            w_busy_nxt  = 1'b0;
          end else begin
            w_state_nxt = RS_RELEASE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RS_RELEASE: begin
        if (w_src_act) begin
          w_state_nxt = RS_ASSERT;
          w_out_nxt   = '0;
          w_cnt_nxt   = '0;
          w_ch_nxt    = '0;
          w_busy_nxt  = 1'b1;
`ifdef RSTSEQ_CAUSE_EN
          w_cause_nxt = w_ext_act ? RC_EXT : RC_SW;
`endif
        end else if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (r_ch == CH_W'(k)) w_out_nxt[k] = 1'b1;
          end
          w_cnt_nxt = '0;
          w_ch_nxt  = r_ch + 1'b1;
          if (r_ch == CH_W'(NUM_CH - 1)) begin
            w_state_nxt = RS_DONE;
            w_busy_nxt  = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RS_DONE: begin
        if (w_src_act) begin
          w_state_nxt = RS_ASSERT;
          w_out_nxt   = '0;
          w_cnt_nxt   = '0;
          w_ch_nxt    = '0;
          w_busy_nxt  = 1'b1;
`ifdef RSTSEQ_CAUSE_EN
          w_cause_nxt = w_ext_act ? RC_EXT : RC_SW;
`endif
        end
      end
      default: begin
        w_state_nxt = RS_ASSERT;
        w_out_nxt   = '0;
        w_cnt_nxt   = '0;
        w_ch_nxt    = '0;
        w_busy_nxt  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RS_ASSERT;
      r_cnt   <= '0;
      r_ch    <= '0;
      r_out   <= '0;
      r_busy  <= 1'b1;
`ifdef RSTSEQ_CAUSE_EN
      r_cause <= RC_POR;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ch    <= w_ch_nxt;
      r_out   <= w_out_nxt;
      r_busy  <= w_busy_nxt;
`ifdef RSTSEQ_CAUSE_EN
      r_cause <= w_cause_nxt;
`endif
    end
  end

  assign rst_n_out = r_out;
  assign busy      = r_busy;
`ifdef RSTSEQ_CAUSE_EN
  assign rst_cause = r_cause;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer.
// Timing-rule reference model, directed and random stimulus.
module tb_reset_sequencer;

  localparam int N  = 4;
  localparam int SS = 2;
  localparam int S  = 16;
  localparam int G  = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ext_n;
  logic         sw;
  logic [N-1:0] out;
  logic         busy;
  logic [0:0]   out1;
  logic         busy1;
`ifdef RSTSEQ_CAUSE_EN
  logic [1:0]   cause;
  logic [1:0]   cause1;
`endif

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_CH(N), .SYNC_STAGES(SS),
    .STRETCH_CYCLES(S), .GAP_CYCLES(G)
  ) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ext_rst_n_async (ext_n),
    .sw_rst_req      (sw),
    .rst_n_out       (out),
    .busy            (busy)
`ifdef RSTSEQ_CAUSE_EN
    ,
    .rst_cause       (cause)
`endif
  );

  reset_sequencer #(
    .NUM_CH(1), .SYNC_STAGES(2),
    .STRETCH_CYCLES(1), .GAP_CYCLES(1)
  ) u_dut1 (
    .clk             (clk),
    .rst_n           (rst_n),
    .ext_rst_n_async (ext_n),
    .sw_rst_req      (sw),
    .rst_n_out       (out1),
    .busy            (busy1)
`ifdef RSTSEQ_CAUSE_EN
    ,
    .rst_cause       (cause1)
`endif
  );

  int n_pass = 0;
  int n_chk  = 0;
  int n_fail = 0;

  // model: edge count, edge of last active sample, pin history
  int         n    = 0;
  int         last = 0;
  int         m_nrel;
  logic [1:0] m_cause = 2'b00;
  bit         hist[$];

  function automatic int nrel_of(int d);
    int r;
    if (d < S) return 0;
    r = 1 + (d - S) / G;
    if (r > N) r = N;
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit act;
    bit ext_act;
    int prev;
    logic [31:0] e_out;
    @(posedge clk);
    n++;
    if (!rst_n) begin
      last = n;
      hist.delete();
      for (int i = 0; i < SS; i++) hist.push_back(1'b0);
      m_cause = 2'b00;
    end else begin
      ext_act = (hist[0] == 1'b0);
      act     = ext_act || sw;
      prev    = nrel_of(n - 1 - last);
      if (act) begin
        if (prev > 0) m_cause = ext_act ? 2'b01 : 2'b10;
        last = n;
      end
      void'(hist.pop_front());
      hist.push_back(ext_n);
    end
    m_nrel = nrel_of(n - last);
    #1;
    e_out = (32'd1 << m_nrel) - 32'd1;
    chk("rst_n_out", 32'(out), e_out);
    chk("busy", 32'(busy), 32'(m_nrel < N));
    chk("order", 32'((out & (out + 1'b1)) == '0), 32'd1);
`ifdef RSTSEQ_CAUSE_EN
    chk("cause", 32'(cause), 32'(m_cause));
`endif
  endtask

  int e0;
  int sw_left  = 0;
  int ext_left = 0;

  initial begin
    rst_n = 1'b0;
    ext_n = 1'b1;
    sw    = 1'b0;
    for (int i = 0; i < SS; i++) hist.push_back(1'b0);

    // power-on
    repeat (5) step();
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_sync", 32'(u_dut.u_sync.r_q), 32'd0);
    rst_n = 1'b1;
    e0 = n;
    while (n < e0 + 42) begin
      step();
      if (n == e0 + 2) chk("n1_e2", 32'(out1), 32'd0);
      if (n == e0 + 3) begin
        chk("n1_e3_out", 32'(out1), 32'd1);
        chk("n1_e3_busy", 32'(busy1), 32'd0);
      end
      if (n == e0 + 17) chk("po_e17", 32'(out), 32'h0);
      if (n == e0 + 18) chk("po_e18", 32'(out), 32'h1);
      if (n == e0 + 26) chk("po_e26", 32'(out), 32'h3);
      if (n == e0 + 34) chk("po_e34", 32'(out), 32'h7);
      if (n == e0 + 41) chk("po_e41_busy", 32'(busy), 32'd1);
    end
    chk("po_e42", 32'(out), 32'hF);
    chk("po_e42_busy", 32'(busy), 32'd0);
    repeat (3) step();

    // sw pulse in done
    sw = 1'b1;
    step();
    e0 = n;
    sw = 1'b0;
    chk("sw_out", 32'(out), 32'h0);
    chk("sw_busy", 32'(busy), 32'd1);
`ifdef RSTSEQ_CAUSE_EN
    chk("sw_cause", 32'(cause), 32'h2);
`endif
    while (n < e0 + 40) begin
      step();
      if (n == e0 + 15) chk("sw_e15", 32'(out), 32'h0);
      if (n == e0 + 16) chk("sw_e16", 32'(out), 32'h1);
    end
    chk("sw_e40", 32'(out), 32'hF);
    chk("sw_e40_busy", 32'(busy), 32'd0);

    // ext low 3 cycles after channel 1 released
    sw = 1'b1;
    step();
    sw = 1'b0;
    for (int i = 0; i < 200 && out != 4'h3; i++) step();
    chk("ext_pre", 32'(out), 32'h3);
    ext_n = 1'b0;
    repeat (3) step();
    ext_n = 1'b1;
    chk("ext_out", 32'(out), 32'h0);
    chk("ext_busy", 32'(busy), 32'd1);
`ifdef RSTSEQ_CAUSE_EN
    chk("ext_cause", 32'(cause), 32'h1);
`endif
    repeat (60) step();
    chk("ext_full", 32'(out), 32'hF);

    // request coincident with channel-2 release edge
    sw = 1'b1;
    step();
    sw = 1'b0;
    for (int i = 0; i < 200 && (n - last + 1) != S + 2 * G; i++)
      step();
    sw = 1'b1;
    step();
    sw = 1'b0;
    chk("coin_out", 32'(out), 32'h0);
    chk("coin_busy", 32'(busy), 32'd1);
    chk("coin_state", 32'(u_dut.r_state), 32'(rst_seq_pkg::RS_ASSERT));

    // rst_n low mid-release
    for (int i = 0; i < 200 && out != 4'h3; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_out", 32'(out), 32'h0);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_sync", 32'(u_dut.u_sync.r_q), 32'd0);
`ifdef RSTSEQ_CAUSE_EN
    chk("mid_cause", 32'(cause), 32'h0);
`endif
    repeat (50) step();

    // random
    for (int i = 0; i < 800; i++) begin
      if (sw_left > 0) sw_left--;
      else if ($urandom_range(0, 39) == 0)
        sw_left = $urandom_range(1, 3);
      if (ext_left > 0) ext_left--;
      else if ($urandom_range(0, 59) == 0)
        ext_left = $urandom_range(1, 4);
      sw    = (sw_left > 0);
      ext_n = !(ext_left > 0);
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    sw    = 1'b0;
    ext_n = 1'b1;
    rst_n = 1'b1;
    repeat (60) step();
    chk("end_out", 32'(out), 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
